// File: rtl/sram_like_mem_slave.sv
// sram-like responder backed by a word-addressed memory, with
// programmable address-accept and data-return latencies.
module sram_like_mem_slave #(
    parameter int    ADDR_WIDTH = 12,
    parameter int    ADDR_LAT   = 0,
    parameter int    DATA_LAT   = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
    localparam int DW = (DATA_LAT > 0) ? $clog2(DATA_LAT + 1) : 1;
    localparam logic [AW-1:0] A_LAST = AW'(ADDR_LAT);
    localparam logic [DW-1:0] D_LAST = DW'(DATA_LAT);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         acnt_q, acnt_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  data_ok_q, data_ok_d;

    logic                  accept;
    logic                  go_resp;
    logic                  mem_we;
    logic                  cur_wr;
    logic [1:0]            cur_size;
    logic [ADDR_WIDTH+1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [3:0]            cur_mask;
    logic                  unused_addr;

    logic [31:0] mem [DEPTH];

    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    assign accept  = (state_q == IDLE) && req && (acnt_q == A_LAST);
    assign addr_ok = accept && resetn;
    assign rdata   = rdata_q;
    assign data_ok = data_ok_q;

    // With DATA_LAT=0 the response is issued off the accept edge,
    // so the request is taken straight from the ports.
    always_comb begin
        cur_wr    = accept ? wr : wr_q;
        cur_size  = accept ? size : size_q;
        cur_addr  = accept ? addr[ADDR_WIDTH+1:0] : addr_q;
        cur_wdata = accept ? wdata : wdata_q;
        cur_idx   = cur_addr[ADDR_WIDTH+1:2];
        cur_mask  = 4'b1111;
        unique case (cur_size)
            2'b00:   cur_mask = 4'b0001 << cur_addr[1:0];
            2'b01:   cur_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
            default: cur_mask = 4'b1111;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acnt_d    = acnt_q;
        dcnt_d    = dcnt_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        go_resp   = 1'b0;
        data_ok_d = 1'b0;
        rdata_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (!req) begin
                    acnt_d = '0;
                end else if (accept) begin
                    acnt_d  = '0;
                    dcnt_d  = '0;
                    wr_d    = wr;
                    size_d  = size;
                    addr_d  = addr[ADDR_WIDTH+1:0];
                    wdata_d = wdata;
                    if (DATA_LAT == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    acnt_d = acnt_q + 1'b1;
                end
            end
            DATA: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_d == D_LAST) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (go_resp) begin
            data_ok_d = 1'b1;
            rdata_d   = cur_wr ? 32'h0 : mem[cur_idx];
        end
    end

    assign mem_we = go_resp && cur_wr && resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            acnt_q    <= '0;
            dcnt_q    <= '0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            dcnt_q    <= dcnt_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            data_ok_q <= data_ok_d;
        end
    end

    // Memory survives reset; the write lands on the edge that raises data_ok.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_mask[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: two instances with different latencies,
// a transaction-level reference model and directed scenarios.
module tb_sram_like_mem_slave;

    localparam int AWID  = 12;
    localparam int DEPTH = 1 << AWID;

    logic        clk;
    logic        resetn;
    logic        req_s   [2];
    logic        wr_s    [2];
    logic [1:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        aok_s   [2];
    logic        dok_s   [2];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int AL = (g == 0) ? 0 : 3;
        localparam int DL = (g == 0) ? 2 : 1;

        sram_like_mem_slave #(
            .ADDR_WIDTH(AWID),
            .ADDR_LAT  (AL),
            .DATA_LAT  (DL),
            .INIT_FILE ("")
        ) dut (
            .clk    (clk),
            .resetn (resetn),
            .req    (req_s[g]),
            .wr     (wr_s[g]),
            .size   (size_s[g]),
            .addr   (addr_s[g]),
            .wdata  (wdata_s[g]),
            .rdata  (rdata_s[g]),
            .addr_ok(aok_s[g]),
            .data_ok(dok_s[g])
        );

        // Transaction model: a request must be seen for AL+1 consecutive
        // free cycles; its response appears DL+1 cycles after the accept.
        int          cnt;
        int          left;
        bit          busy;
        bit          resp;
        bit          mw;
        logic [1:0]  msz;
        logic [31:0] ma;
        logic [31:0] mwd;
        bit          eaok;
        bit          edok;
        logic [31:0] erd;
        logic [31:0] mm [int];

        function automatic logic [3:0] lanes(logic [1:0] sz, logic [31:0] a);
            if (sz == 2'b00) return 4'b0001 << a[1:0];
            if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
            return 4'b1111;
        endfunction

        task automatic respond();
            int          idx;
            logic [31:0] w;
            logic [3:0]  m;
            idx  = int'((ma >> 2) % DEPTH);
            resp = 1'b1;
            edok = 1'b1;
            w    = mm.exists(idx) ? mm[idx] : 32'hxxxxxxxx;
            if (mw) begin
                m = lanes(msz, ma);
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) w[8*b +: 8] = mwd[8*b +: 8];
                end
                mm[idx] = w;
                erd     = 32'h0;
            end else begin
                erd = w;
            end
        endtask

        initial begin
            cnt  = 0;
            left = 0;
            busy = 1'b0;
            resp = 1'b0;
            edok = 1'b0;
            erd  = 32'h0;
            forever begin
                @(negedge clk);
                eaok = resetn && !busy && req_s[g] && (cnt == AL);
                if (!resetn) begin
                    chk($sformatf("u%0d.rst.addr_ok", g), 32'(aok_s[g]), 32'h0);
                    chk($sformatf("u%0d.rst.data_ok", g), 32'(dok_s[g]), 32'h0);
                    chk($sformatf("u%0d.rst.rdata", g), rdata_s[g], 32'h0);
                end else begin
                    chk($sformatf("u%0d.addr_ok", g), 32'(aok_s[g]), 32'(eaok));
                    chk($sformatf("u%0d.data_ok", g), 32'(dok_s[g]), 32'(edok));
                    if (edok && !$isunknown(erd))
                        chk($sformatf("u%0d.rdata", g), rdata_s[g], erd);
                end
                if (!resetn) begin
                    busy = 1'b0;
                    resp = 1'b0;
                    cnt  = 0;
                    edok = 1'b0;
                    erd  = 32'h0;
                end else begin
                    edok = 1'b0;
                    erd  = 32'h0;
                    if (resp) begin
                        resp = 1'b0;
                        busy = 1'b0;
                    end else if (busy) begin
                        left--;
                        if (left == 0) respond();
                    end else if (req_s[g]) begin
                        if (cnt == AL) begin
                            mw   = wr_s[g];
                            msz  = size_s[g];
                            ma   = addr_s[g];
                            mwd  = wdata_s[g];
                            busy = 1'b1;
                            cnt  = 0;
                            left = DL;
                            if (left == 0) respond();
                        end else begin
                            cnt++;
                        end
                    end else begin
                        cnt = 0;
                    end
                end
            end
        end
    end

    // Called at the start of a cycle; returns at the start of the cycle
    // after data_ok. acyc = cycles waited for addr_ok, dcyc = edges from
    // the accept cycle to the data_ok cycle.
    task automatic xact(input int g, input bit w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int acyc,
                        output int dcyc);
        acyc = -1;
        dcyc = -1;
        rd   = 32'hxxxxxxxx;
        req_s[g]   = 1'b1;
        wr_s[g]    = w;
        size_s[g]  = sz;
        addr_s[g]  = a;
        wdata_s[g] = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (aok_s[g]) begin
                acyc = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_s[g] = 1'b0;
        if (acyc < 0) begin
            chk("xact.addr_ok_timeout", 32'hffffffff, 32'h0);
            return;
        end
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (dok_s[g]) begin
                dcyc = i;
                rd   = rdata_s[g];
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        if (dcyc < 0) chk("xact.data_ok_timeout", 32'hffffffff, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          ac;
        int          dc;
        int          na;
        int          nd;
        resetn = 1'b0;
        for (int g = 0; g < 2; g++) begin
            req_s[g]   = 1'b0;
            wr_s[g]    = 1'b0;
            size_s[g]  = 2'b00;
            addr_s[g]  = 32'h0;
            wdata_s[g] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Word write then read, accept same cycle, data_ok 3 cycles later
        xact(0, 1'b1, 2'b10, 32'h40, 32'hDEADBEEF, rd, ac, dc);
        chk("wr40.acc_cyc", ac, 0);
        chk("wr40.dok_lat", dc, 3);
        chk("wr40.rdata", rd, 32'h0);
        xact(0, 1'b0, 2'b10, 32'h40, 32'h0, rd, ac, dc);
        chk("rd40.acc_cyc", ac, 0);
        chk("rd40.dok_lat", dc, 3);
        chk("rd40.rdata", rd, 32'hDEADBEEF);

        // Byte then half store into a preloaded word
        xact(0, 1'b1, 2'b10, 32'h80, 32'h11223344, rd, ac, dc);
        xact(0, 1'b1, 2'b00, 32'h81, 32'h0000AA00, rd, ac, dc);
        xact(0, 1'b1, 2'b01, 32'h82, 32'hBBCC0000, rd, ac, dc);
        xact(0, 1'b0, 2'b10, 32'h80, 32'h0, rd, ac, dc);
        chk("mask.rdata", rd, 32'hBBCCAA44);

        // ADDR_LAT=3 instance: accept on the 4th cycle of req
        xact(1, 1'b1, 2'b10, 32'h200, 32'h12345678, rd, ac, dc);
        chk("al3.acc_cyc", ac, 3);
        chk("al3.dok_lat", dc, 2);
        req_s[1]   = 1'b1;
        wr_s[1]    = 1'b1;
        size_s[1]  = 2'b10;
        addr_s[1]  = 32'h200;
        wdata_s[1] = 32'hFFFFFFFF;
        na = 0;
        repeat (2) begin
            @(negedge clk);
            na += int'(aok_s[1]);
            @(posedge clk);
            #1;
        end
        req_s[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("al3.withdrawn_aok", na, 0);
        xact(1, 1'b0, 2'b10, 32'h200, 32'h0, rd, ac, dc);
        chk("al3.restart_acc", ac, 3);
        chk("al3.no_change", rd, 32'h12345678);

        // req held through busy cycles: accepts at cycles 3 and 9 of 14
        req_s[1] = 1'b1;
        wr_s[1]  = 1'b0;
        addr_s[1] = 32'h200;
        na = 0;
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            na += int'(aok_s[1]);
            nd += int'(dok_s[1]);
            if (aok_s[1] && dok_s[1]) chk("held.overlap", 1, 0);
            @(posedge clk);
            #1;
        end
        req_s[1] = 1'b0;
        chk("held.n_addr_ok", na, 2);
        chk("held.n_data_ok", nd, 2);
        repeat (3) @(posedge clk);
        #1;

        // Dirty-miss style: write 0x100, then read aliasing index 0x4100
        xact(0, 1'b1, 2'b10, 32'h100, 32'hCAFEF00D, rd, ac, dc);
        xact(0, 1'b0, 2'b10, 32'h4100, 32'h0, rd, ac, dc);
        chk("alias.acc_cyc", ac, 0);
        chk("alias.rdata", rd, 32'hCAFEF00D);

        // Reset while a write sits in DATA: the write must be lost
        xact(0, 1'b1, 2'b10, 32'h10, 32'h0, rd, ac, dc);
        req_s[0]   = 1'b1;
        wr_s[0]    = 1'b1;
        size_s[0]  = 2'b10;
        addr_s[0]  = 32'h10;
        wdata_s[0] = 32'h5555AAAA;
        @(negedge clk);
        chk("rstw.addr_ok", 32'(aok_s[0]), 32'h1);
        @(posedge clk);
        #1;
        req_s[0] = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rstw.async_aok", 32'(aok_s[0]), 32'h0);
        chk("rstw.async_dok", 32'(dok_s[0]), 32'h0);
        chk("rstw.async_rdata", rdata_s[0], 32'h0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        xact(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, ac, dc);
        chk("rstw.old_value", rd, 32'h0);
        chk("rstw.dok_lat", dc, 3);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
